// File: rtl/onehot_monitor.sv
// onehot_monitor: registered one-hot / zero-hot / multi-hot checker with saturating
// error counters and a sticky alarm after THRESH consecutive failures.
// Ports: clk, rst_n (async active-low), en (sample enable), zero_ok (allow all-zero),
//   clr (sync clear), sig (monitored vector) -> valid_o, pass_o, fail_zero_o,
//   fail_multi_o, idx_o, err_cnt_o, consec_o, alarm_o, fail_val_o.
// Optional macro ONEHOT_MON_POPCOUNT_EN adds pop_o (registered popcount) and a
//   simulation warning on each failing sample.
module onehot_monitor #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3,
    parameter int IDX_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             zero_ok,
    input  logic             clr,
    input  logic [WIDTH-1:0] sig,
    output logic             valid_o,
    output logic             pass_o,
    output logic             fail_zero_o,
    output logic             fail_multi_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] consec_o,
    output logic             alarm_o,
`ifdef ONEHOT_MON_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] pop_o,
`endif
    output logic [WIDTH-1:0] fail_val_o
);
    localparam int PW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, CHECK, ALARM} state_t;
    state_t state, state_n;

    logic [PW-1:0]    pop;
    logic [IDX_W-1:0] idx;
    logic             one, zero, multi, fail;
    logic [CNT_W-1:0] err_inc, consec_inc, consec_n;

    always_comb begin
        pop = '0;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(sig[i]);
            if (sig[i]) idx = IDX_W'(i);
        end
        one        = pop == PW'(1);
        zero       = pop == '0;
        multi      = !one && !zero;
        fail       = multi || (zero && !zero_ok);
        err_inc    = err_cnt_o == '1 ? err_cnt_o : err_cnt_o + CNT_W'(1);
        consec_inc = consec_o == '1 ? consec_o : consec_o + CNT_W'(1);
        consec_n   = fail ? consec_inc : '0;
        // ALARM is sticky; only clr leaves it, and the alarm decision uses the
        // post-update run length so alarm_o lines up with consec_o==THRESH.
        state_n = clr ? (en ? CHECK : IDLE)
                : (state == ALARM || (en && consec_n >= CNT_W'(THRESH))) ? ALARM
                : en ? CHECK : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid_o      <= 1'b0;
            pass_o       <= 1'b0;
            fail_zero_o  <= 1'b0;
            fail_multi_o <= 1'b0;
            idx_o        <= '0;
            err_cnt_o    <= '0;
            consec_o     <= '0;
            alarm_o      <= 1'b0;
            fail_val_o   <= '0;
        end else begin
            state   <= state_n;
            alarm_o <= state_n == ALARM;
            if (clr) begin
                valid_o      <= 1'b0;
                pass_o       <= 1'b0;
                fail_zero_o  <= 1'b0;
                fail_multi_o <= 1'b0;
                idx_o        <= '0;
                err_cnt_o    <= '0;
                consec_o     <= '0;
                fail_val_o   <= '0;
            end else begin
                valid_o      <= en;
                pass_o       <= en && !fail;
                fail_zero_o  <= en && zero && !zero_ok;
                fail_multi_o <= en && multi;
                idx_o        <= (en && one) ? idx : '0;
                if (en) begin
                    consec_o <= consec_n;
                    if (fail) err_cnt_o <= err_inc;
                    // capture only the first failure since reset/clr
                    if (fail && err_cnt_o == '0) fail_val_o <= sig;
                end
            end
        end
    end

`ifdef ONEHOT_MON_POPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pop_o <= '0;
        else pop_o <= (en && !clr) ? pop : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && en && !clr && fail) $warning("onehot_monitor failure at %0t sig=%b", $time, sig);
    end
`endif
endmodule

// File: tb/tb_onehot_monitor.sv
// tb_onehot_monitor: scoreboard bench for onehot_monitor; a default 4-bit instance
// and an 8-bit instance with 2-bit saturating counters share one stimulus stream.
module tb_onehot_monitor;
    logic clk = 0, rst_n = 0, en = 0, zero_ok = 0, clr = 0;
    logic [7:0] sig = 0;
    always #5 clk = ~clk;

    logic a_valid, a_pass, a_fz, a_fm, a_alarm;
    logic [1:0] a_idx;
    logic [7:0] a_err, a_con;
    logic [3:0] a_fv;
    logic b_valid, b_pass, b_fz, b_fm, b_alarm;
    logic [2:0] b_idx;
    logic [1:0] b_err, b_con;
    logic [7:0] b_fv;

    onehot_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .zero_ok(zero_ok), .clr(clr), .sig(sig[3:0]),
        .valid_o(a_valid), .pass_o(a_pass), .fail_zero_o(a_fz), .fail_multi_o(a_fm),
        .idx_o(a_idx), .err_cnt_o(a_err), .consec_o(a_con), .alarm_o(a_alarm), .fail_val_o(a_fv)
    );

    onehot_monitor #(.WIDTH(8), .CNT_W(2), .THRESH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .zero_ok(zero_ok), .clr(clr), .sig(sig),
        .valid_o(b_valid), .pass_o(b_pass), .fail_zero_o(b_fz), .fail_multi_o(b_fm),
        .idx_o(b_idx), .err_cnt_o(b_err), .consec_o(b_con), .alarm_o(b_alarm), .fail_val_o(b_fv)
    );

    typedef struct {
        bit v, p, fz, fm, al;
        int idx, err, con;
        logic [7:0] fv;
    } exp_t;

    exp_t qa[$], qb[$];
    int total = 0, passed = 0;
    int m_err[2], m_con[2];
    bit m_al[2];
    logic [7:0] m_fv[2];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 0; m_con[d] = 0; m_al[d] = 0; m_fv[d] = 0;
        end
    endtask

    // Reference behaviour: counts bits of the slice each instance sees and
    // applies the classification/counter rules directly.
    function automatic exp_t model(int d, bit e, bit zok, bit c, logic [7:0] s);
        exp_t r = '{default: 0};
        int mx = d ? 3 : 255;
        logic [7:0] v = d ? s : {4'b0, s[3:0]};
        int pc = 0;
        bit ok;
        for (int i = 0; i < 8; i++) pc += int'(v[i]);
        if (c) begin
            m_err[d] = 0; m_con[d] = 0; m_al[d] = 0; m_fv[d] = 0;
        end else if (e) begin
            ok = pc == 1 || (pc == 0 && zok);
            if (!ok) begin
                if (m_err[d] == 0) m_fv[d] = v;
                m_err[d] = m_err[d] < mx ? m_err[d] + 1 : mx;
                m_con[d] = m_con[d] < mx ? m_con[d] + 1 : mx;
            end else m_con[d] = 0;
            if (m_con[d] >= 3) m_al[d] = 1;
            r.v = 1; r.p = ok; r.fz = pc == 0 && !zok; r.fm = pc >= 2;
            if (pc == 1) for (int i = 0; i < 8; i++) if (v == (8'd1 << i)) r.idx = i;
        end
        r.err = m_err[d]; r.con = m_con[d]; r.al = m_al[d]; r.fv = m_fv[d];
        return r;
    endfunction

    task automatic step(bit e, bit zok, bit c, logic [7:0] s);
        @(negedge clk);
        en = e; zero_ok = zok; clr = c; sig = s;
        @(posedge clk);
        qa.push_back(model(0, e, zok, c, s));
        qb.push_back(model(1, e, zok, c, s));
    endtask

    task automatic cmp(string n, exp_t x, bit v, bit p, bit fz, bit fm, int idx, int err,
                       int con, bit al, logic [7:0] fv);
        chk({n, ".valid"}, int'(v), int'(x.v));
        chk({n, ".pass"}, int'(p), int'(x.p));
        chk({n, ".fail_zero"}, int'(fz), int'(x.fz));
        chk({n, ".fail_multi"}, int'(fm), int'(x.fm));
        chk({n, ".idx"}, idx, x.idx);
        chk({n, ".err_cnt"}, err, x.err);
        chk({n, ".consec"}, con, x.con);
        chk({n, ".alarm"}, int'(al), int'(x.al));
        chk({n, ".fail_val"}, int'(fv), int'(x.fv));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (qa.size() != 0) begin
                x = qa.pop_front();
                cmp("A", x, a_valid, a_pass, a_fz, a_fm, int'(a_idx), int'(a_err), int'(a_con),
                    a_alarm, {4'b0, a_fv});
            end
            if (qb.size() != 0) begin
                x = qb.pop_front();
                cmp("B", x, b_valid, b_pass, b_fz, b_fm, int'(b_idx), int'(b_err), int'(b_con),
                    b_alarm, b_fv);
            end
        end
    end

    task automatic check_zero(string n);
        chk({n, ".a_any"}, int'({a_valid, a_pass, a_fz, a_fm, a_alarm, a_idx, a_err, a_con, a_fv} != 0), 0);
        chk({n, ".b_any"}, int'({b_valid, b_pass, b_fz, b_fm, b_alarm, b_idx, b_err, b_con, b_fv} != 0), 0);
    endtask

    initial begin
        int k;
        logic [7:0] s;
        model_reset();
        #2 check_zero("reset");
        #20 rst_n = 1;
        // directed sequence
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(1, 0, 0, 8'hEE);
        step(1, 0, 0, 8'h99);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h08);
        step(1, 0, 1, 8'h08);
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'hFF);
        step(0, 0, 0, 8'h10);
        // async reset while both instances are alarmed, between clock edges
        @(negedge clk);
        #1 rst_n = 0;
        #1 check_zero("async_reset");
        model_reset();
        en = 0;
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0, 8'h01);
        step(0, 1, 0, 8'h03);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            s = k < 5 ? 8'(8'd1 << $urandom_range(0, 7)) : k < 7 ? 8'h00 : 8'($urandom);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, s);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", qa.size() + qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
